// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, forwarding
// select codes and the writer descriptor used by the forwarding compare.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LDUSE = 2'd1,
    MWAIT = 2'd2,
    FAULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    FWD_RF   = 2'b00,
    FWD_EALU = 2'b01,
    FWD_MALU = 2'b10,
    FWD_MLD  = 2'b11
  } fwd_e;

  // One downstream stage that may write the register file.
  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic [4:0] rn;
  } wb_src_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID/EXE/MEM hazard sideband between the pipeline datapath and the controller.
interface pipe_hazard_ctrl_if #(
  parameter int CW = 16
);
  logic [4:0]    rs, rt;
  logic          use_rs, use_rt, pcsrc_tkn;
  logic          ewreg, em2reg;
  logic [4:0]    ern0;
  logic          mwreg, mm2reg, mwmem;
  logic [4:0]    mrn;
  logic          dmem_rdy;
  logic          wpcir, mfreeze, flush_ifid, fault;
  logic [1:0]    fwda, fwdb;
  logic [CW-1:0] stall_cnt;

  modport master (
    output rs, rt, use_rs, use_rt, pcsrc_tkn, ewreg, em2reg, ern0,
           mwreg, mm2reg, mwmem, mrn, dmem_rdy,
    input  wpcir, mfreeze, flush_ifid, fwda, fwdb, fault, stall_cnt
  );

  modport slave (
    input  rs, rt, use_rs, use_rt, pcsrc_tkn, ewreg, em2reg, ern0,
           mwreg, mm2reg, mwmem, mrn, dmem_rdy,
    output wpcir, mfreeze, flush_ifid, fwda, fwdb, fault, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for one ID-stage source operand; the EXE ALU result is the
// youngest value so it wins over anything in MEM. r0 is never forwarded.
module pipe_fwd_sel
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src_i,
  input  wb_src_t    exe_i,
  input  wb_src_t    mem_i,
  output fwd_e       fwd_o
);
  logic e_hit, m_hit;

  assign e_hit = exe_i.wreg && (exe_i.rn != 5'd0) && (exe_i.rn == src_i);
  assign m_hit = mem_i.wreg && (mem_i.rn != 5'd0) && (mem_i.rn == src_i);

  always_comb begin
    fwd_o = FWD_RF;
    if (e_hit && !exe_i.m2reg)     fwd_o = FWD_EALU;
    else if (m_hit && mem_i.m2reg) fwd_o = FWD_MLD;
    else if (m_hit)                fwd_o = FWD_MALU;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller: operand forwarding, load-use bubble, branch flush
// and memory-wait freeze with timeout fault and saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAXWAIT = 15,
  parameter int CW      = 16
) (
  input  logic              clock,
  input  logic              reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam int WW = $clog2(MAXWAIT + 1);

  state_e          state_q, state_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic [CW-1:0]   stall_q, stall_d;
  logic            lu, mw;
  logic            wpcir, mfreeze, flush;
  logic [1:0][4:0] src;
  fwd_e            fwd [2];
  wb_src_t         e_src, m_src;

  assign e_src = '{wreg: bus.ewreg, m2reg: bus.em2reg, rn: bus.ern0};
  assign m_src = '{wreg: bus.mwreg, m2reg: bus.mm2reg, rn: bus.mrn};
  assign src   = {bus.rt, bus.rs};

  for (genvar g = 0; g < 2; g++) begin : g_fwd
    pipe_fwd_sel u_fwd (
      .src_i (src[g]),
      .exe_i (e_src),
      .mem_i (m_src),
      .fwd_o (fwd[g])
    );
  end

  assign lu = bus.ewreg && bus.em2reg && (bus.ern0 != 5'd0) &&
              ((bus.use_rs && bus.ern0 == bus.rs) || (bus.use_rt && bus.ern0 == bus.rt));
  assign mw = (bus.mm2reg || bus.mwmem) && !bus.dmem_rdy;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    wpcir   = 1'b1;
    mfreeze = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      RUN, LDUSE: begin
        if (mw) begin
          mfreeze = 1'b1;
          wpcir   = 1'b0;
          wait_d  = WW'(1);
          state_d = (MAXWAIT <= 1) ? FAULT : MWAIT;
        end else if (state_q == RUN && lu) begin
          wpcir   = 1'b0;
          state_d = LDUSE;
        end else begin
          flush   = bus.pcsrc_tkn;
          state_d = RUN;
        end
      end
      MWAIT: begin
        if (mw) begin
          mfreeze = 1'b1;
          wpcir   = 1'b0;
          wait_d  = wait_q + WW'(1);
          if (wait_d == WW'(MAXWAIT)) state_d = FAULT;
        end else begin
          // Released instruction may itself be a load-use consumer: bubble it.
          wait_d  = '0;
          state_d = RUN;
          wpcir   = !lu;
          flush   = bus.pcsrc_tkn && !lu;
        end
      end
      FAULT: begin
        mfreeze = 1'b1;
        wpcir   = 1'b0;
      end
      default: state_d = RUN;
    endcase
    stall_d = stall_q;
    if ((!wpcir || mfreeze) && stall_q != '1) stall_d = stall_q + CW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
    end
  end

  assign bus.wpcir      = reset ? 1'b1 : wpcir;
  assign bus.mfreeze    = reset ? 1'b0 : mfreeze;
  assign bus.flush_ifid = reset ? 1'b0 : flush;
  assign bus.fwda       = reset ? FWD_RF : fwd[0];
  assign bus.fwdb       = reset ? FWD_RF : fwd[1];
  assign bus.fault      = (state_q == FAULT);
  assign bus.stall_cnt  = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: single-cycle vector table from RUN plus
// sequences for load-use, memory wait, timeout fault and counter saturation.
module tb_pipe_hazard_ctrl;
  import pipe_ctrl_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  pipe_hazard_ctrl_if #(.CW(16)) ifc ();
  pipe_hazard_ctrl_if #(.CW(3))  ifc2 ();

  pipe_hazard_ctrl #(.MAXWAIT(15), .CW(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (ifc.slave)
  );

  pipe_hazard_ctrl #(.MAXWAIT(15), .CW(3)) dut_sat (
    .clock (clock),
    .reset (reset),
    .bus   (ifc2.slave)
  );

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       use_rs, use_rt, pc, ew, em;
    logic [4:0] ern;
    logic       mw, mm, mwm;
    logic [4:0] mrn;
    logic       rdy;
    logic       x_wp, x_mf, x_fl;
    logic [1:0] x_fa, x_fb;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ifc.rs = '0; ifc.rt = '0; ifc.use_rs = 0; ifc.use_rt = 0; ifc.pcsrc_tkn = 0;
    ifc.ewreg = 0; ifc.em2reg = 0; ifc.ern0 = '0;
    ifc.mwreg = 0; ifc.mm2reg = 0; ifc.mwmem = 0; ifc.mrn = '0; ifc.dmem_rdy = 1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    ifc.rs = v.rs; ifc.rt = v.rt; ifc.use_rs = v.use_rs; ifc.use_rt = v.use_rt;
    ifc.pcsrc_tkn = v.pc; ifc.ewreg = v.ew; ifc.em2reg = v.em; ifc.ern0 = v.ern;
    ifc.mwreg = v.mw; ifc.mm2reg = v.mm; ifc.mwmem = v.mwm; ifc.mrn = v.mrn;
    ifc.dmem_rdy = v.rdy;
  endtask

  initial begin
    ifc2.rs = '0; ifc2.rt = '0; ifc2.use_rs = 0; ifc2.use_rt = 0; ifc2.pcsrc_tkn = 0;
    ifc2.ewreg = 0; ifc2.em2reg = 0; ifc2.ern0 = '0;
    ifc2.mwreg = 1; ifc2.mm2reg = 1; ifc2.mwmem = 0; ifc2.mrn = 5'd2; ifc2.dmem_rdy = 0;
  end

  initial begin
    //          rs rt urs urt pc ew em ern mw mm mwm mrn rdy wp mf fl fa fb
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    vecs[1]  = '{5, 0, 1, 0, 0, 1, 0, 5, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0};
    vecs[2]  = '{0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    vecs[3]  = '{0, 8, 0, 1, 0, 0, 0, 0, 1, 1, 0, 8, 1, 1, 0, 0, 0, 3};
    vecs[4]  = '{3, 3, 1, 1, 0, 0, 0, 0, 1, 0, 0, 3, 1, 1, 0, 0, 2, 2};
    vecs[5]  = '{7, 0, 1, 0, 0, 1, 0, 7, 1, 1, 0, 7, 1, 1, 0, 0, 1, 0};
    vecs[6]  = '{9, 0, 1, 0, 0, 1, 1, 9, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[7]  = '{9, 0, 0, 0, 0, 1, 1, 9, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    vecs[8]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0};
    vecs[9]  = '{0, 6, 0, 1, 1, 1, 1, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
    vecs[10] = '{4, 0, 1, 0, 0, 1, 1, 4, 1, 1, 0, 4, 0, 0, 1, 0, 3, 0};
    vecs[11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    vecs[12] = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 1, 0, 0, 0, 0};
    vecs[13] = '{6, 5, 1, 1, 0, 1, 0, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1};

    // Outputs are forced benign while reset is high, even with hazards present.
    reset = 1'b1;
    apply(vecs[10]);
    #1;
    chk("rst_wpcir", int'(ifc.wpcir), 1);
    chk("rst_mfreeze", int'(ifc.mfreeze), 0);
    chk("rst_fwda", int'(ifc.fwda), 0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("rst_stall_cnt", int'(ifc.stall_cnt), 0);
    chk("rst_fault", int'(ifc.fault), 0);
    chk("rst_state", int'(dut.state_q), int'(RUN));
    chk("idle_wpcir", int'(ifc.wpcir), 1);
    chk("idle_fwdb", int'(ifc.fwdb), 0);

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i]);
      #1;
      chk($sformatf("v%0d_wpcir", i), int'(ifc.wpcir), int'(vecs[i].x_wp));
      chk($sformatf("v%0d_mfreeze", i), int'(ifc.mfreeze), int'(vecs[i].x_mf));
      chk($sformatf("v%0d_flush", i), int'(ifc.flush_ifid), int'(vecs[i].x_fl));
      chk($sformatf("v%0d_fwda", i), int'(ifc.fwda), int'(vecs[i].x_fa));
      chk($sformatf("v%0d_fwdb", i), int'(ifc.fwdb), int'(vecs[i].x_fb));
      idle();
      do_reset();
    end

    // Load-use: one bubble, then the load is forwarded from MEM.
    idle();
    ifc.ewreg = 1; ifc.em2reg = 1; ifc.ern0 = 5'd8; ifc.rt = 5'd8; ifc.use_rt = 1;
    #1;
    chk("lu_wpcir", int'(ifc.wpcir), 0);
    tick();
    chk("lu_state", int'(dut.state_q), int'(LDUSE));
    ifc.ewreg = 0; ifc.em2reg = 0; ifc.ern0 = '0;
    ifc.mwreg = 1; ifc.mm2reg = 1; ifc.mrn = 5'd8;
    #1;
    chk("lu2_wpcir", int'(ifc.wpcir), 1);
    chk("lu2_fwdb", int'(ifc.fwdb), 3);
    tick();
    idle();
    #1;
    chk("lu_stall_cnt", int'(ifc.stall_cnt), 1);
    chk("lu_back_run", int'(dut.state_q), int'(RUN));
    do_reset();

    // Memory wait for three cycles, then ready.
    idle();
    ifc.mwreg = 1; ifc.mm2reg = 1; ifc.mrn = 5'd4; ifc.dmem_rdy = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("mw_mfreeze%0d", c), int'(ifc.mfreeze), 1);
      chk($sformatf("mw_wpcir%0d", c), int'(ifc.wpcir), 0);
      tick();
    end
    ifc.dmem_rdy = 1;
    #1;
    chk("mw_rdy_mfreeze", int'(ifc.mfreeze), 0);
    chk("mw_rdy_wpcir", int'(ifc.wpcir), 1);
    tick();
    idle();
    #1;
    chk("mw_state", int'(dut.state_q), int'(RUN));
    chk("mw_stall_cnt", int'(ifc.stall_cnt), 3);
    do_reset();

    // Timeout: fault rises after exactly MAXWAIT not-ready cycles and sticks.
    idle();
    ifc.mwreg = 1; ifc.mm2reg = 1; ifc.mrn = 5'd4; ifc.dmem_rdy = 0;
    for (int c = 1; c <= 15; c++) begin
      #1;
      if (ifc.fault !== 1'b0) chk($sformatf("to_early_fault%0d", c), int'(ifc.fault), 0);
      tick();
    end
    chk("to_fault", int'(ifc.fault), 1);
    chk("to_mfreeze", int'(ifc.mfreeze), 1);
    chk("to_wpcir", int'(ifc.wpcir), 0);
    ifc.dmem_rdy = 1;
    repeat (3) tick();
    chk("to_sticky", int'(ifc.fault), 1);
    chk("to_stall_cnt", int'(ifc.stall_cnt), 18);
    reset = 1'b1;
    #1;
    chk("to_rst_wpcir", int'(ifc.wpcir), 1);
    chk("to_rst_mfreeze", int'(ifc.mfreeze), 0);
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("to_cleared", int'(ifc.fault), 0);
    chk("to_cnt_cleared", int'(ifc.stall_cnt), 0);
    chk("to_state", int'(dut.state_q), int'(RUN));

    // Saturation on the 3-bit counter instance (stalls every cycle).
    do_reset();
    repeat (6) tick();
    chk("sat_cnt6", int'(ifc2.stall_cnt), 6);
    repeat (5) tick();
    chk("sat_cnt_max", int'(ifc2.stall_cnt), 7);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
